// File: rtl/soc_rst_seq.sv
// -----------------------------------------------------------------------------
// soc_rst_seq : parametrised SoC reset sequencer
//
// Purpose
//   Drives NUM_CH active-low reset channels. Assertion follows rst
//   asynchronously. Release is synchronised to clk, held for HOLD_CYCLES, and
//   then staggered by STAGE_GAP cycles per channel in ascending index order.
//   A software request re-runs the hold/release sequence. An optional
//   watchdog does the same when it expires. The cause of the last reset is
//   reported.
//
// Configuration
//   SOC_RST_SEQ_WDT_EN : when defined, the watchdog is built (counts only in
//                        RUN, cleared by wdt_kick). When undefined, wdt_kick is
//                        ignored and wdt_timeout is tied low.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-low reset (low = asserted)
//   sw_rst_req   in   software reset request, level-sampled each cycle
//   wdt_kick     in   watchdog restart strobe
//   rst_out_n    out  [NUM_CH] per-channel reset, active-low
//   seq_busy     out  high while any channel is still held in reset
//   seq_done     out  high once every channel is released (state RUN)
//   rst_cause    out  [2] last reset cause: 0 power-on, 1 software, 2 watchdog
//   wdt_timeout  out  one-cycle pulse on watchdog expiry
// -----------------------------------------------------------------------------
module soc_rst_seq #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned WDT_LIMIT   = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst_req,
  input  logic              wdt_kick,
  output logic [NUM_CH-1:0] rst_out_n,
  output logic              seq_busy,
  output logic              seq_done,
  output logic [1:0]        rst_cause,
  output logic              wdt_timeout
);

  // One shared counter serves hold, stage gap and watchdog; it is sized for
  // the largest of the three so it never has to wrap.
  localparam int unsigned MAX_HG  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CNT_MAX = (MAX_HG > WDT_LIMIT) ? MAX_HG : WDT_LIMIT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // The SYNC->HOLD state transition acts as the final synchroniser flop, so
  // only SYNC_STAGES-1 dedicated stages are needed here.
  localparam int unsigned SYNC_W  = SYNC_STAGES - 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
`ifdef SOC_RST_SEQ_WDT_EN
  localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_LIMIT - 1);
`endif

  typedef enum logic [1:0] {
    S_SYNC    = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_SW  = 2'd1,
    CAUSE_WDT = 2'd2
  } cause_e;

  state_e              state_q, state_d;
  logic [SYNC_W-1:0]   sync_q,  sync_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  // Released channels form a thermometer code: bit k set means channel k is
  // out of reset. Releasing the next channel is a shift-in of a one.
  logic [NUM_CH-1:0]   ch_q,    ch_d;
  logic [NUM_CH-1:0]   ch_next;
  cause_e              cause_q, cause_d;
`ifdef SOC_RST_SEQ_WDT_EN
  logic                wdt_to_q, wdt_to_d;
`else
  logic                unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick;
`endif

  // ---------------------------------------------------------------------------
  // State / datapath register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational process.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_SYNC;
      sync_q   <= '0;
      cnt_q    <= '0;
      ch_q     <= '0;
      cause_q  <= CAUSE_POR;
`ifdef SOC_RST_SEQ_WDT_EN
      wdt_to_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      cause_q  <= cause_d;
`ifdef SOC_RST_SEQ_WDT_EN
      wdt_to_q <= wdt_to_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    cause_d  = cause_q;
    sync_d   = SYNC_W'({sync_q, 1'b1});
    ch_next  = NUM_CH'({ch_q, 1'b1});
`ifdef SOC_RST_SEQ_WDT_EN
    wdt_to_d = 1'b0;
`endif

    unique case (state_q)
      S_SYNC: begin
        if (sync_q[SYNC_W-1]) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end

      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          ch_d    = ch_next;
          cnt_d   = '0;
          // With a single channel the first release is also the last.
          state_d = (&ch_next) ? S_RUN : S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          ch_d    = ch_next;
          cnt_d   = '0;
          state_d = (&ch_next) ? S_RUN : S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RUN: begin
`ifdef SOC_RST_SEQ_WDT_EN
        if (wdt_kick) begin
          cnt_d = '0;
        end else if (cnt_q == WDT_LAST) begin
          wdt_to_d = 1'b1;
          ch_d     = '0;
          cause_d  = CAUSE_WDT;
          cnt_d    = '0;
          state_d  = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        cnt_d = '0;
`endif
      end

      default: state_d = S_SYNC;
    endcase

    // A software request overrides everything outside SYNC, including a
    // coincident watchdog expiry, and keeps restarting HOLD while held high.
    if (sw_rst_req && (state_q != S_SYNC)) begin
      state_d  = S_HOLD;
      cnt_d    = '0;
      ch_d     = '0;
      cause_d  = CAUSE_SW;
`ifdef SOC_RST_SEQ_WDT_EN
      wdt_to_d = 1'b0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from registers only)
  // ---------------------------------------------------------------------------
  always_comb begin
    rst_out_n   = ch_q;
    seq_done    = (state_q == S_RUN);
    seq_busy    = (state_q != S_RUN);
    rst_cause   = cause_q;
`ifdef SOC_RST_SEQ_WDT_EN
    wdt_timeout = wdt_to_q;
`else
    wdt_timeout = 1'b0;
`endif
  end

endmodule

// File: doc/soc_rst_seq.md
# soc_rst_seq

Parametrised reset sequencer for the SoC top level. It replaces the single hand-driven reset pulse used in simulation with a synthesizable block. Reset assertion is asynchronous; release is synchronised and staggered. It drives NUM_CH independent active-low reset outputs, covering core, memories and peripherals. Release order is channel 0 first, then ascending index, with a fixed gap between channels. It also supports a software-requested re-reset and reports the cause of the last reset.

## Interface
Parameters:
- NUM_CH, 4: number of reset output channels (1..16)
- SYNC_STAGES, 2: reset-release synchroniser depth (≥2)
- HOLD_CYCLES, 16: cycles all outputs stay asserted after synchronised release (≥1)
- STAGE_GAP, 4: cycles between successive channel releases (≥1)
- WDT_LIMIT, 1000: watchdog timeout in cycles (≥2; used only when the watchdog is compiled in)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset; low = reset asserted
- sw_rst_req  in  1  software reset request; level-sampled each cycle
- wdt_kick  in  1  watchdog restart strobe
- rst_out_n  out  NUM_CH  per-channel reset, active-low
- seq_busy  out  1  high while any channel is held in reset
- seq_done  out  1  high when all channels are released (state RUN)
- rst_cause  out  2  cause of last reset: 0 = power-on (rst), 1 = software, 2 = watchdog
- wdt_timeout  out  1  one-cycle pulse when the watchdog expires

## Operation
- States: SYNC, HOLD, RELEASE, RUN.
- rst low: asynchronously clear everything.
  - rst_out_n = 0, seq_busy = 1, seq_done = 0, rst_cause = 0, wdt_timeout = 0.
  - Synchroniser is cleared and the state is SYNC.
- SYNC: wait for the synchroniser output to go high, then enter HOLD with the counter at 0.
- HOLD: increment the counter. When it reaches HOLD_CYCLES-1, set rst_out_n[0] = 1 and enter RELEASE with channel index 1 and the counter at 0.
- RELEASE: count STAGE_GAP cycles, then set rst_out_n[idx] = 1 and increment idx.
  - The release of channel NUM_CH-1 moves the block to RUN in the same edge.
  - NUM_CH = 1: the block goes from HOLD directly to RUN.
- RUN: seq_done = 1 and seq_busy = 0.
- sw_rst_req = 1 in any state except SYNC:
  - Next edge: rst_out_n = 0, rst_cause = 1, counter = 0, state = HOLD.
  - A request during HOLD or RELEASE restarts HOLD from zero.
  - A request held high keeps the block in HOLD.
  - The request is ignored in SYNC.
- Released channels never re-assert except through rst low, sw_rst_req, or watchdog expiry.
- Counter width is $clog2(max(HOLD_CYCLES, STAGE_GAP, WDT_LIMIT)+1). Counters never wrap.

## Timing
- Edge numbering: E1 is the first rising edge with rst high. Release edges:
  - synchroniser output rises at E(SYNC_STAGES)
  - rst_out_n[0] rises at E(SYNC_STAGES+HOLD_CYCLES)
  - rst_out_n[k] rises at E(SYNC_STAGES+HOLD_CYCLES+k·STAGE_GAP)
  - seq_done and the seq_busy fall occur on the same edge as the last channel's release
- With defaults: channel 0 at E18, channels 1, 2, 3 at E22, E26, E30.
- sw_rst_req sampled high at edge N: outputs go low at edge N (registered).
  - Channel 0 releases at N+HOLD_CYCLES, provided the request has deasserted by N+1.
- rst assertion mid-sequence takes effect immediately, without waiting for a clock. The full sequence restarts from SYNC.
- All outputs are registered; none is combinationally derived from inputs.

## Configuration
- SOC_RST_SEQ_WDT_EN defined:
  - The watchdog counter runs only in RUN. It is cleared on wdt_kick and on leaving RUN.
  - When the counter reaches WDT_LIMIT-1 with wdt_kick low, the next edge does all of the following:
    - wdt_timeout = 1 for one cycle
    - rst_out_n = 0
    - rst_cause = 2
    - state = HOLD
  - If sw_rst_req and expiry coincide on the same edge, software wins and rst_cause = 1.
- SOC_RST_SEQ_WDT_EN undefined:
  - No watchdog logic is built. wdt_kick is ignored and wdt_timeout is tied to 0.
  - rst_cause never takes the value 2. The port list is unchanged.

## Test plan
- Power-on with defaults: rst low for 3 cycles, then high.
  - rst_out_n goes 0000 → 0001 at E18, 0011 at E22, 0111 at E26, 1111 at E30.
  - seq_done rises at E30. rst_cause = 0.
- Software reset: sw_rst_req pulsed for one cycle at edge 40 in RUN.
  - rst_out_n = 0000 at E40, seq_done = 0.
  - Channel 0 releases at E56, all channels by E68. rst_cause = 1.
- Request during RELEASE: sw_rst_req at E24 (channels 0 and 1 released).
  - All channels go low at E24. Channel 0 releases at E40.
- Asynchronous reset mid-RELEASE: rst low between clock edges at roughly E25.
  - rst_out_n = 0000 before the next edge, state = SYNC, rst_cause = 0.
  - After rst returns high, the full sequence replays.
- Watchdog, with macro defined and WDT_LIMIT = 10:
  - wdt_kick every 8 cycles: no timeout occurs.
  - Kicks stop: wdt_timeout pulses 10 cycles after the last kick, all channels are asserted, rst_cause = 2, and the sequence restarts.
- Parameter sweep: NUM_CH = 1, HOLD_CYCLES = 1, STAGE_GAP = 1.
  - Channel 0 and seq_done rise together at E3.
  - Without the macro, wdt_timeout stays 0 for the whole run.
